// File: rtl/life_seq_ctrl_pkg.sv
// Shared Game of Life definitions: sequencer state codes, button priority and board geometry.
// Used by the sequencer, the board generator and the evolution engine.
package life_pkg;

  localparam int STATE_W = 3;

  // Board geometry shared with gen_board and the engine; L is the flattened cell count.
  localparam int W = 32;
  localparam int H = 24;
  localparam int L = W * H;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_SEED      = 3'd2,
    S_LOAD      = 3'd3,
    S_PAUSED    = 3'd4,
    S_RUN       = 3'd5,
    S_STEP_WAIT = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    BTN_NONE,
    BTN_RESEED,
    BTN_PAUSE,
    BTN_STEP,
    BTN_START
  } btn_e;

  // Only the highest-priority button of a cycle survives; the rest are dropped.
  function automatic btn_e btn_pick(input logic reseed, input logic pause,
                                    input logic step, input logic start);
    if (reseed)     return BTN_RESEED;
    else if (pause) return BTN_PAUSE;
    else if (step)  return BTN_STEP;
    else if (start) return BTN_START;
    else            return BTN_NONE;
  endfunction

endpackage

// File: rtl/life_seq_ctrl_if.sv
// Sequencer-facing bundle: user buttons/speed in, generator/engine control out.
// master = the sequencer, slave = the surrounding datapath and button logic.
interface life_seq_ctrl_if #(
  parameter int GEN_W = 16
) ();
  import life_pkg::*;

  logic               btn_start;
  logic               btn_pause;
  logic               btn_step;
  logic               btn_reseed;
  logic [1:0]         speed;
  logic               gen_done;
  logic               step_ack;
  logic               gen_clr;
  logic               gen_en;
  logic               load_board;
  logic               step_req;
  logic [GEN_W-1:0]   gen_count;
  logic               running;
  logic [STATE_W-1:0] state_out;

  modport master (
    input  btn_start, btn_pause, btn_step, btn_reseed, speed, gen_done, step_ack,
    output gen_clr, gen_en, load_board, step_req, gen_count, running, state_out
  );

  modport slave (
    output btn_start, btn_pause, btn_step, btn_reseed, speed, gen_done, step_ack,
    input  gen_clr, gen_en, load_board, step_req, gen_count, running, state_out
  );

endinterface

// File: rtl/life_seq_ctrl_tick_div.sv
// Generation tick divider: counts while enabled and pulses tick on the last cycle of a
// (TICK_DIV >> speed)-cycle period; tick is combinational from the count register.
module life_tick_div #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      limit;

  // The >= compare lets a mid-period speed-up past the new limit wrap immediately.
  always_comb begin
    limit = 32'(TICK_DIV) >> speed;
    tick  = en && ((32'(cnt_q) + 32'd1) >= limit);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/life_seq_ctrl.sv
// Game of Life sequencer: seeds the board, loads the engine, then schedules generation steps.
// Outputs are registered except step_req, which is decoded from state and held until step_ack.
module life_seq_ctrl
  import life_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int GEN_W    = 16
) (
  input logic             clk,
  input logic             rst,
  life_seq_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic             autorun_q, autorun_d;
  logic             ret_run_q, ret_run_d;
  logic             reseed_pend_q, reseed_pend_d;
  logic             seed_settle_q, seed_settle_d;
  logic             gen_clr_q, gen_clr_d;
  logic             gen_en_q, gen_en_d;
  logic             load_board_q, load_board_d;
  logic             running_q, running_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic             tick;
  btn_e             btn;

  life_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q != S_RUN),
    .en    (state_q == S_RUN),
    .speed (bus.speed),
    .tick  (tick)
  );

  always_comb begin
    state_d       = state_q;
    autorun_d     = autorun_q;
    ret_run_d     = ret_run_q;
    reseed_pend_d = reseed_pend_q;
    gen_count_d   = gen_count_q;
    seed_settle_d = 1'b0;
    btn           = btn_pick(bus.btn_reseed, bus.btn_pause, bus.btn_step, bus.btn_start);

    case (state_q)
      S_IDLE: begin
        if (btn == BTN_START) begin
          state_d   = S_CLEAR;
          autorun_d = 1'b1;
        end else if (btn == BTN_RESEED) begin
          state_d   = S_CLEAR;
          autorun_d = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d       = S_SEED;
        seed_settle_d = 1'b1;
      end
      // The generator count is still settling on the first SEED cycle; its done is stale.
      S_SEED: begin
        if (!seed_settle_q && bus.gen_done) state_d = S_LOAD;
      end
      S_LOAD: begin
        gen_count_d = '0;
        autorun_d   = 1'b0;
        state_d     = autorun_q ? S_RUN : S_PAUSED;
      end
      S_PAUSED: begin
        if (btn == BTN_RESEED) begin
          state_d   = S_CLEAR;
          autorun_d = 1'b0;
        end else if (btn == BTN_START) begin
          state_d = S_RUN;
        end else if (btn == BTN_STEP) begin
          state_d   = S_STEP_WAIT;
          ret_run_d = 1'b0;
        end
      end
      S_RUN: begin
        if (btn == BTN_RESEED) begin
          state_d   = S_CLEAR;
          autorun_d = 1'b1;
        end else if (btn == BTN_PAUSE) begin
          state_d = S_PAUSED;
        end else if (tick) begin
          state_d   = S_STEP_WAIT;
          ret_run_d = 1'b1;
        end
      end
      S_STEP_WAIT: begin
        if (btn == BTN_RESEED) begin
          reseed_pend_d = 1'b1;
          autorun_d     = ret_run_q;
        end else if (btn == BTN_PAUSE) begin
          ret_run_d = 1'b0;
        end
        // Buttons only update the flags here; the request is never withdrawn before ack.
        if (bus.step_ack) begin
          gen_count_d = (&gen_count_q) ? gen_count_q : gen_count_q + GEN_W'(1);
          if (reseed_pend_d) begin
            state_d       = S_CLEAR;
            reseed_pend_d = 1'b0;
          end else begin
            state_d = ret_run_d ? S_RUN : S_PAUSED;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    gen_clr_d    = (state_d == S_CLEAR);
    gen_en_d     = (state_d == S_SEED);
    load_board_d = (state_d == S_LOAD);
    running_d    = (state_d == S_RUN) || ((state_d == S_STEP_WAIT) && ret_run_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      autorun_q     <= 1'b0;
      ret_run_q     <= 1'b0;
      reseed_pend_q <= 1'b0;
      seed_settle_q <= 1'b0;
      gen_clr_q     <= 1'b0;
      gen_en_q      <= 1'b0;
      load_board_q  <= 1'b0;
      running_q     <= 1'b0;
      gen_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      autorun_q     <= autorun_d;
      ret_run_q     <= ret_run_d;
      reseed_pend_q <= reseed_pend_d;
      seed_settle_q <= seed_settle_d;
      gen_clr_q     <= gen_clr_d;
      gen_en_q      <= gen_en_d;
      load_board_q  <= load_board_d;
      running_q     <= running_d;
      gen_count_q   <= gen_count_d;
    end
  end

  assign bus.gen_clr    = gen_clr_q;
  assign bus.gen_en     = gen_en_q;
  assign bus.load_board = load_board_q;
  assign bus.step_req   = (state_q == S_STEP_WAIT);
  assign bus.gen_count  = gen_count_q;
  assign bus.running    = running_q;
  assign bus.state_out  = state_q;

endmodule

// File: tb/tb_life_seq_ctrl.sv
// Directed bench for life_seq_ctrl with TICK_DIV=8; expected values are hand-derived.
module tb_life_seq_ctrl;
  import life_pkg::*;

  localparam int TICK_DIV = 8;
  localparam int GEN_W    = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  life_seq_ctrl_if #(.GEN_W(GEN_W)) bus ();

  life_seq_ctrl #(.TICK_DIV(TICK_DIV), .GEN_W(GEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {gen_clr, gen_en, load_board, step_req, running}
  function automatic logic [4:0] outs();
    return {bus.gen_clr, bus.gen_en, bus.load_board, bus.step_req, bus.running};
  endfunction

  initial begin
    rst            = 1'b1;
    bus.btn_start  = 1'b0;
    bus.btn_pause  = 1'b0;
    bus.btn_step   = 1'b0;
    bus.btn_reseed = 1'b0;
    bus.speed      = 2'd0;
    bus.gen_done   = 1'b0;
    bus.step_ack   = 1'b0;
    cyc(2);
    check_eq("rst_state", 32'(bus.state_out), 32'd0);
    check_eq("rst_outs", 32'(outs()), 32'd0);
    check_eq("rst_count", 32'(bus.gen_count), 32'd0);
    rst = 1'b0;
    cyc(1);

    // 1: start from IDLE, seed with done arriving in the fifth SEED cycle, then run
    bus.btn_start = 1'b1;
    cyc(1);
    bus.btn_start = 1'b0;
    check_eq("t1_clear_state", 32'(bus.state_out), 32'd1);
    check_eq("t1_clear_outs", 32'(outs()), 32'b10000);
    cyc(1);
    check_eq("t1_seed_outs", 32'(outs()), 32'b01000);
    cyc(4);
    check_eq("t1_seed5_state", 32'(bus.state_out), 32'd2);
    bus.gen_done = 1'b1;
    cyc(1);
    check_eq("t1_load_state", 32'(bus.state_out), 32'd3);
    check_eq("t1_load_outs", 32'(outs()), 32'b00100);
    cyc(1);
    check_eq("t1_run_state", 32'(bus.state_out), 32'd5);
    check_eq("t1_run_outs", 32'(outs()), 32'b00001);
    check_eq("t1_run_count", 32'(bus.gen_count), 32'd0);
    cyc(7);
    check_eq("t1_run7_outs", 32'(outs()), 32'b00001);
    cyc(1);
    check_eq("t1_req_state", 32'(bus.state_out), 32'd6);
    check_eq("t1_req_outs", 32'(outs()), 32'b00011);

    // 2: speed=2, ack three cycles into each request, four steps
    bus.speed = 2'd2;
    for (int k = 0; k < 4; k++) begin
      cyc(3);
      check_eq("t2_hold", 32'(bus.step_req), 32'd1);
      bus.step_ack = 1'b1;
      cyc(1);
      bus.step_ack = 1'b0;
      check_eq("t2_back_run", 32'(bus.state_out), 32'd5);
      check_eq("t2_count", 32'(bus.gen_count), 32'(k + 1));
      if (k < 3) begin
        cyc(1);
        check_eq("t2_run2", 32'(bus.state_out), 32'd5);
        cyc(1);
        check_eq("t2_period", 32'(bus.step_req), 32'd1);
      end
    end
    bus.btn_pause = 1'b1;
    cyc(1);
    bus.btn_pause = 1'b0;
    check_eq("t2_paused", 32'(bus.state_out), 32'd4);
    check_eq("t2_paused_outs", 32'(outs()), 32'd0);

    // 3: stray ack, pause-over-step priority, three single steps
    bus.step_ack = 1'b1;
    cyc(1);
    bus.step_ack = 1'b0;
    check_eq("t3_stray_ack", 32'(bus.gen_count), 32'd4);
    bus.btn_pause = 1'b1;
    bus.btn_step  = 1'b1;
    cyc(1);
    bus.btn_pause = 1'b0;
    bus.btn_step  = 1'b0;
    check_eq("t3_pause_over_step", 32'(outs()), 32'd0);
    for (int k = 0; k < 3; k++) begin
      bus.btn_step = 1'b1;
      cyc(1);
      check_eq("t3_req_outs", 32'(outs()), 32'b00010);
      cyc(1);
      bus.btn_step = 1'b0;
      check_eq("t3_step_ignored", 32'(bus.state_out), 32'd6);
      bus.step_ack = 1'b1;
      cyc(1);
      bus.step_ack = 1'b0;
      check_eq("t3_paused", 32'(bus.state_out), 32'd4);
      check_eq("t3_count", 32'(bus.gen_count), 32'(5 + k));
    end

    // 4: pause then reseed while waiting, ack after 10 cycles, instant-done reseed
    bus.btn_start = 1'b1;
    cyc(1);
    bus.btn_start = 1'b0;
    cyc(2);
    check_eq("t4_req_outs", 32'(outs()), 32'b00011);
    for (int i = 0; i < 10; i++) begin
      check_eq("t4_held", 32'(bus.step_req), 32'd1);
      bus.btn_pause  = (i == 0);
      bus.btn_reseed = (i == 1);
      cyc(1);
    end
    check_eq("t4_ret_cleared", 32'(outs()), 32'b00010);
    bus.step_ack = 1'b1;
    cyc(1);
    bus.step_ack = 1'b0;
    check_eq("t4_clear_state", 32'(bus.state_out), 32'd1);
    check_eq("t4_count", 32'(bus.gen_count), 32'd8);
    cyc(2);
    check_eq("t4_seed2", 32'(bus.state_out), 32'd2);
    cyc(1);
    check_eq("t4_load", 32'(bus.state_out), 32'd3);
    cyc(1);
    check_eq("t4_paused", 32'(bus.state_out), 32'd4);
    check_eq("t4_count0", 32'(bus.gen_count), 32'd0);

    // 5: reseed beats start; saturation; mid-period speed change
    bus.btn_reseed = 1'b1;
    bus.btn_start  = 1'b1;
    cyc(1);
    bus.btn_reseed = 1'b0;
    bus.btn_start  = 1'b0;
    check_eq("t5_clear", 32'(bus.state_out), 32'd1);
    cyc(4);
    check_eq("t5_not_run", 32'(bus.state_out), 32'd4);
    force dut.gen_count_q = 16'hFFFE;
    cyc(1);
    release dut.gen_count_q;
    check_eq("t5_preload", 32'(bus.gen_count), 32'hFFFE);
    for (int k = 0; k < 2; k++) begin
      bus.btn_step = 1'b1;
      cyc(1);
      bus.btn_step = 1'b0;
      bus.step_ack = 1'b1;
      cyc(1);
      bus.step_ack = 1'b0;
      check_eq("t5_sat", 32'(bus.gen_count), 32'hFFFF);
    end
    bus.speed     = 2'd0;
    bus.btn_start = 1'b1;
    cyc(1);
    bus.btn_start = 1'b0;
    cyc(5);
    check_eq("t5_run5", 32'(bus.state_out), 32'd5);
    bus.speed = 2'd2;
    cyc(1);
    check_eq("t5_speed_chg", 32'(bus.state_out), 32'd6);

    // 6: asynchronous reset during STEP_WAIT and during SEED
    #2 rst = 1'b1;
    #1;
    check_eq("t6_sw_state", 32'(bus.state_out), 32'd0);
    check_eq("t6_sw_outs", 32'(outs()), 32'd0);
    check_eq("t6_sw_count", 32'(bus.gen_count), 32'd0);
    cyc(1);
    rst          = 1'b0;
    bus.gen_done = 1'b0;
    bus.btn_start = 1'b1;
    cyc(1);
    bus.btn_start = 1'b0;
    cyc(1);
    check_eq("t6_seed_en", 32'(outs()), 32'b01000);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_seed_state", 32'(bus.state_out), 32'd0);
    check_eq("t6_seed_outs", 32'(outs()), 32'd0);
    cyc(1);
    rst          = 1'b0;
    bus.gen_done = 1'b1;
    cyc(3);
    check_eq("t6_no_load", 32'(outs()), 32'd0);
    check_eq("t6_idle", 32'(bus.state_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
